// File: rtl/lvds_adc_pkg.sv
// lvds_adc_pkg
// Shared definitions for the LVDS ADC receive path: the frame-alignment
// state type and the default parameter values used by the deserializer.
package lvds_adc_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,   // searching for a rising frame edge
        ACQUIRE = 2'd1,   // aligned, counting good words before trusting them
        LOCKED  = 2'd2    // aligned and trusted, words are delivered
    } lvds_state_t;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_ERR_WIDTH  = 8;

endpackage : lvds_adc_pkg

// File: rtl/diff_to_single_ended.sv
// diff_to_single_ended
// Input-buffer wrapper converting one differential pin pair to a
// single-ended signal. Vendor flows map this onto their differential input
// primitive; the generic body models an ideal receiver.
//
// Ports:
//   I   in   positive leg of the pair
//   IB  in   negative leg of the pair
//   O   out  single-ended receiver output
module diff_to_single_ended #(
    parameter IOSTANDARD = "LVDS_25",
    parameter DIFF_TERM  = "TRUE"
) (
    input  logic I,
    input  logic IB,
    output logic O
);

    // A single-ended standard, or an unterminated pair, is resolved from the
    // positive leg alone; a terminated differential pair only reads as 1
    // when the legs are in their complementary high state.
    if ((IOSTANDARD == "LVCMOS25") || (IOSTANDARD == "LVCMOS33") ||
        (DIFF_TERM != "TRUE")) begin : g_single
        assign O = I;
    end else begin : g_diff
        assign O = I & ~IB;
    end

endmodule : diff_to_single_ended

// File: rtl/lvds_adc_deserializer.sv
// lvds_adc_deserializer
// Receives the ADC serial data lane and frame lane, aligns on the frame
// marker (high during the MSB of every word) and emits parallel sample
// words with a one-cycle valid strobe once LOCK_COUNT consecutive
// well-formed frames have been seen.
//
// Ports:
//   clk           in   bit clock, one serial bit per rising edge
//   rst_n         in   asynchronous active-low reset
//   data_p/data_n in   LVDS serial data lane, MSB first
//   frame_p/frame_n in LVDS frame lane
//   err_clear     in   synchronous clear of err_count (wins over increment)
//   sample_out    out  last delivered word
//   sample_valid  out  one-cycle strobe, sample_out is new
//   locked        out  high while in LOCKED
//   err_count     out  saturating count of frame errors
module lvds_adc_deserializer
    import lvds_adc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int ERR_WIDTH  = DEF_ERR_WIDTH,
    parameter     IOSTANDARD = "LVDS_25",
    parameter     DIFF_TERM  = "TRUE"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_p,
    input  logic                  data_n,
    input  logic                  frame_p,
    input  logic                  frame_n,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  locked,
    output logic [ERR_WIDTH-1:0]  err_count
);

    localparam int IDX_W  = $clog2(DATA_WIDTH);
    localparam int GOOD_W = $clog2(LOCK_COUNT) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [GOOD_W-1:0] LAST_GOOD = GOOD_W'(LOCK_COUNT - 1);

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (&v) ? v : v + ERR_WIDTH'(1);
    endfunction

    logic data_i;
    logic frame_i;

    diff_to_single_ended #(
        .IOSTANDARD (IOSTANDARD),
        .DIFF_TERM  (DIFF_TERM)
    ) u_data_buf (
        .I  (data_p),
        .IB (data_n),
        .O  (data_i)
    );

    diff_to_single_ended #(
        .IOSTANDARD (IOSTANDARD),
        .DIFF_TERM  (DIFF_TERM)
    ) u_frame_buf (
        .I  (frame_p),
        .IB (frame_n),
        .O  (frame_i)
    );

    logic                  data_s;
    logic                  frame_s;
    logic                  frame_q;
    logic [DATA_WIDTH-2:0] shift_q;
    logic [IDX_W-1:0]      idx;
    logic [GOOD_W-1:0]     good_cnt;
    lvds_state_t           state_q;

    lvds_state_t           state_d;
    logic [IDX_W-1:0]      idx_d;
    logic [GOOD_W-1:0]     good_d;
    logic                  frame_err;
    logic                  word_done;

    // idx is the position, within the current word, of the bit now held in
    // data_s. The bit that raised the frame in HUNT is bit 0, so the next
    // bit evaluated is position 1.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx;
        good_d    = good_cnt;
        frame_err = 1'b0;
        word_done = 1'b0;
        case (state_q)
            HUNT: begin
                idx_d  = '0;
                good_d = '0;
                if (frame_s && !frame_q) begin
                    state_d = ACQUIRE;
                    idx_d   = IDX_W'(1);
                end
            end
            ACQUIRE, LOCKED: begin
                if (frame_s != (idx == '0)) begin
                    // Misaligned frame: drop the partial word and require a
                    // fresh rising edge rather than reusing this bit.
                    frame_err = 1'b1;
                    state_d   = HUNT;
                    idx_d     = '0;
                    good_d    = '0;
                end else if (idx == LAST_IDX) begin
                    word_done = 1'b1;
                    idx_d     = '0;
                    if (state_q == ACQUIRE) begin
                        if (good_cnt == LAST_GOOD) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_cnt + GOOD_W'(1);
                        end
                    end
                end else begin
                    idx_d = idx + IDX_W'(1);
                end
            end
            default: begin
                state_d = HUNT;
                idx_d   = '0;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s       <= 1'b0;
            frame_s      <= 1'b0;
            frame_q      <= 1'b0;
            shift_q      <= '0;
            idx          <= '0;
            good_cnt     <= '0;
            state_q      <= HUNT;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            err_count    <= '0;
        end else begin
            // Stage boundary: pin capture into the single sync register.
            data_s  <= data_i;
            frame_s <= frame_i;
            frame_q <= frame_s;

            // Stage boundary: alignment and word assembly. The shifter runs
            // every cycle, so on the last bit it already holds bits 0..W-2.
            shift_q  <= {shift_q[DATA_WIDTH-3:0], data_s};
            idx      <= idx_d;
            good_cnt <= good_d;
            state_q  <= state_d;
            locked   <= (state_d == LOCKED);

            sample_valid <= word_done && (state_q == LOCKED);
            if (word_done && (state_q == LOCKED)) begin
                sample_out <= {shift_q, data_s};
            end

            if (err_clear) begin
                err_count <= '0;
            end else if (frame_err) begin
                err_count <= sat_inc(err_count);
            end
        end
    end

endmodule : lvds_adc_deserializer

// File: tb/tb_lvds_adc_deserializer.sv
// tb_lvds_adc_deserializer
// Drives serial words onto the differential lanes and compares every cycle
// against a word-level reference model that scans the captured bit history.
module tb_lvds_adc_deserializer;

    localparam int W      = 14;
    localparam int LOCK_N = 4;
    localparam int EW     = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          data_p, data_n, frame_p, frame_n, err_clear;
    logic [W-1:0]  sample_out;
    logic          sample_valid, locked;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    assign data_n  = ~data_p;
    assign frame_n = ~frame_p;

    lvds_adc_deserializer #(
        .DATA_WIDTH (W),
        .LOCK_COUNT (LOCK_N),
        .ERR_WIDTH  (EW),
        .IOSTANDARD ("LVDS_25"),
        .DIFF_TERM  ("TRUE")
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_p       (data_p),
        .data_n       (data_n),
        .frame_p      (frame_p),
        .frame_n      (frame_n),
        .err_clear    (err_clear),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .locked       (locked),
        .err_count    (err_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: history of bits as captured into the sync register
    // (index 0 is the reset value), plus the position where the current
    // word began. Words are assembled from the history when complete.
    bit           hf[$];
    bit           hd[$];
    bit           m_hunt;
    int           m_start;
    int           m_good;
    bit           m_locked;
    bit           m_valid;
    logic [W-1:0] m_out;
    int           m_err;

    function automatic void model_reset();
        hf.delete(); hd.delete();
        hf.push_back(1'b0); hd.push_back(1'b0);
        m_hunt = 1'b1; m_start = 0; m_good = 0; m_locked = 1'b0;
        m_valid = 1'b0; m_out = '0; m_err = 0;
    endfunction

    function automatic void model_step(input bit clr);
        int b;
        int j;
        bit prevf;
        bit inc;
        logic [W-1:0] w;
        b = hf.size() - 1;
        inc = 1'b0;
        m_valid = 1'b0;
        prevf = (b > 0) ? hf[b-1] : 1'b0;
        if (m_hunt) begin
            if (hf[b] && !prevf) begin
                m_hunt = 1'b0;
                m_start = b;
            end
        end else begin
            j = b - m_start;
            if (hf[b] != (j == 0)) begin
                inc = 1'b1; m_hunt = 1'b1; m_locked = 1'b0; m_good = 0;
            end else if (j == W - 1) begin
                for (int k = 0; k < W; k++) w[W-1-k] = hd[m_start + k];
                if (m_locked) begin
                    m_valid = 1'b1;
                    m_out = w;
                end else begin
                    m_good++;
                    if (m_good == LOCK_N) begin
                        m_locked = 1'b1;
                        m_good = 0;
                    end
                end
                m_start = b + 1;
            end
        end
        if (clr) m_err = 0;
        else if (inc && m_err < ERR_MAX) m_err++;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(err_clear);
            hf.push_back(frame_p);
            hd.push_back(data_p);
        end
        #1;
        chk("valid", 32'(sample_valid), 32'(m_valid));
        chk("sample_out", 32'(sample_out), 32'(m_out));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("err_count", 32'(err_count), 32'(m_err));
    endtask

    task automatic drive(input bit d, input bit f, input bit c = 1'b0);
        data_p = d; frame_p = f; err_clear = c;
        tick();
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nbits);
        for (int j = 0; j < nbits; j++) drive(w[W-1-j], j == 0);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_bits(w, W);
    endtask

    function automatic logic [W-1:0] rnd_word();
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        data_p = 1'b0; frame_p = 1'b0; err_clear = 1'b0;
        #2;
        chk({tag, "_rst_out"}, 32'(sample_out), 32'h0);
        chk({tag, "_rst_valid"}, 32'(sample_valid), 32'h0);
        chk({tag, "_rst_locked"}, 32'(locked), 32'h0);
        chk({tag, "_rst_err"}, 32'(err_count), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic         exp_valid;
        logic [W-1:0] exp_out;
        logic         exp_locked;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{14'h2AAA, 1'b0, 14'h0000, 1'b0};
        tbl[1] = '{14'h1555, 1'b0, 14'h0000, 1'b0};
        tbl[2] = '{14'h3FFF, 1'b0, 14'h0000, 1'b0};
        tbl[3] = '{14'h0000, 1'b0, 14'h0000, 1'b1};
        tbl[4] = '{14'h0001, 1'b1, 14'h0001, 1'b1};
        tbl[5] = '{14'h2000, 1'b1, 14'h2000, 1'b1};

        rst_n = 1'b1; data_p = 1'b0; frame_p = 1'b0; err_clear = 1'b0;
        model_reset();
        #1;
        do_reset("init");

        // Clean words: results of word i appear on the edge carrying the
        // MSB of word i+1, i.e. W edges after word i's MSB edge.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < W; j++) begin
                drive(tbl[i].word[W-1-j], j == 0);
                if (j == 0 && i > 0) begin
                    chk($sformatf("tbl%0d_valid", i-1), 32'(sample_valid), 32'(tbl[i-1].exp_valid));
                    chk($sformatf("tbl%0d_out", i-1), 32'(sample_out), 32'(tbl[i-1].exp_out));
                    chk($sformatf("tbl%0d_locked", i-1), 32'(locked), 32'(tbl[i-1].exp_locked));
                end
            end
        end
        drive(1'b0, 1'b0);
        chk("tbl5_valid", 32'(sample_valid), 32'(tbl[5].exp_valid));
        chk("tbl5_out", 32'(sample_out), 32'(tbl[5].exp_out));
        chk("tbl5_locked", 32'(locked), 32'(tbl[5].exp_locked));
        chk("tbl_err", 32'(err_count), 32'h0);

        // Random idle with frame low, then aligned words.
        do_reset("idle");
        repeat (50) drive(1'($urandom_range(0, 1)), 1'b0);
        chk("idle_err", 32'(err_count), 32'h0);
        chk("idle_locked", 32'(locked), 32'h0);
        repeat (5) send_word(rnd_word());
        chk("idle_relock", 32'(locked), 32'h1);

        // Frame one bit early while locked.
        send_word(rnd_word());
        send_bits(rnd_word(), W - 1);
        send_word(rnd_word());
        chk("early_locked", 32'(locked), 32'h0);
        chk("early_err", 32'(err_count), 32'h1);
        repeat (5) send_word(rnd_word());
        chk("early_relock", 32'(locked), 32'h1);

        // Error counter saturation, then clear colliding with an error.
        repeat (300) begin
            drive(1'($urandom_range(0, 1)), 1'b1);
            drive(1'($urandom_range(0, 1)), 1'b1);
            drive(1'($urandom_range(0, 1)), 1'b0);
        end
        chk("sat_err", 32'(err_count), 32'(ERR_MAX));
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("clear_wins", 32'(err_count), 32'h0);

        // Reset in the middle of a locked word.
        repeat (5) send_word(rnd_word());
        chk("pre_rst_locked", 32'(locked), 32'h1);
        send_bits(rnd_word(), 7);
        do_reset("midword");
        repeat (3) send_word(rnd_word());
        chk("rst_3words_locked", 32'(locked), 32'h0);
        repeat (2) send_word(rnd_word());
        chk("rst_relock", 32'(locked), 32'h1);

        // Frame held high for three bits.
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        repeat (W) drive(1'($urandom_range(0, 1)), 1'b0);
        chk("long_frame_err", 32'(err_count), 32'h1);
        chk("long_frame_locked", 32'(locked), 32'h0);
        repeat (5) send_word(rnd_word());
        chk("long_frame_relock", 32'(locked), 32'h1);

        // Random mix of good words, short words and idle gaps.
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7) send_word(rnd_word());
            else if (sel < 9) send_bits(rnd_word(), $urandom_range(1, W - 1));
            else repeat ($urandom_range(1, 5)) drive(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lvds_adc_deserializer
